data_mem_lsu: RTL and testbench

//   Parametrised byte-addressable data memory with a load/store front end for the RISC-V core.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/data_mem_lsu_load_align.sv | 29 ++
 rtl/data_mem_lsu.sv | 134 +++++++++++++
 tb/tb_data_mem_lsu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings and helpers for the data memory load/store unit.
package riscv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word and extends it.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        result  = '0;
        case (size)
            SIZE_B:  result = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_H:  result = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            SIZE_W:  result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with load/store front end and post-reset init sequencer.
module data_mem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int          IW = idx_w(DEPTH);
    localparam int unsigned CW = ADDR_W + 32;

    logic [31:0]       mem [DEPTH];
    state_t            state;
    logic [IW-1:0]     cnt;

    logic [ADDR_W-3:0] widx;
    logic [IW-1:0]     idx;
    logic [1:0]        lane;
    logic              accept;
    logic              oor;
    logic              misalign;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [31:0]       rd_word;
    logic [31:0]       ld_data;

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign accept    = req_valid & req_ready;

    assign widx = req_addr[ADDR_W-1:2];
    assign idx  = widx[IW-1:0];
    assign lane = req_addr[1:0];

    // Range check done at a width wide enough for both the word index and DEPTH.
    assign oor = CW'(widx) >= CW'(DEPTH);

    always_comb begin
        misalign = 1'b0;
        be       = '0;
        wlanes   = '0;
        case (req_size)
            SIZE_B: begin
                be     = 4'b0001 << lane;
                wlanes = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                misalign = lane[0];
                be       = 4'b0011 << {lane[1], 1'b0};
                wlanes   = {2{req_wdata[15:0]}};
            end
            SIZE_W: begin
                misalign = (lane != 2'b00);
                be       = 4'b1111;
                wlanes   = req_wdata;
            end
            default: begin
                misalign = 1'b0;
                be       = '0;
                wlanes   = '0;
            end
        endcase
    end

    assign err = (req_size == SIZE_X) | misalign | oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + IW'(1);
            if (INIT_EN == 0 || cnt == IW'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Array has no reset; init writes and stores share the single write port.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            if (INIT_EN != 0) begin
                mem[cnt] <= 32'(cnt);
            end
        end else if (accept && req_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[idx];

    load_align u_load_align (
        .word        (rd_word),
        .lane        (lane),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .result      (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (err || req_we) ? '0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu with DEPTH=8.
module tb_data_mem_lsu;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b10;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int checks = 0;
    int errors = 0;
    int cyc;

    data_mem_lsu #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INIT_EN (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Issue one request, return #1 after the accept edge with the response visible.
    task automatic one_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        set_req(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic rsp_check(input string tag, input logic [31:0] rdata, input logic err);
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, rdata);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, err});
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_err"}, {31'b0, rsp_err}, 32'd0);
        check({tag, "_idone"}, {31'b0, init_done}, 32'd0);
    endtask

    // Counts posedges until init_done rises, bounded so a stuck sequencer still reports.
    task automatic wait_init(input string tag);
        cyc = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (init_done) break;
        end
        check({tag, "_cycles"}, cyc, DEPTH);
        check({tag, "_idone"}, {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        #12;
        zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        // A request during INIT must be ignored.
        set_req(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("init_ignore_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_init("init1");

        one_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        rsp_check("lw_1c", 32'h0000_0007, 1'b0);
        one_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        rsp_check("lw_00", 32'h0000_0000, 1'b0);
        @(posedge clk); #1;
        check("idle_valid", {31'b0, rsp_valid}, 32'd0);
        check("idle_hold", rsp_rdata, 32'h0000_0000);

        one_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
        rsp_check("sw_10", 32'h0, 1'b0);
        one_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        rsp_check("lb_10", 32'h0000_0001, 1'b0);
        one_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        rsp_check("lb_13", 32'hFFFF_FF80, 1'b0);
        one_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        rsp_check("lbu_13", 32'h0000_0080, 1'b0);
        one_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        rsp_check("lh_12", 32'hFFFF_80FF, 1'b0);
        one_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        rsp_check("lhu_12", 32'h0000_80FF, 1'b0);
        one_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        rsp_check("lh_10", 32'h0000_7F01, 1'b0);
        @(posedge clk); #1;
        check("idle_hold2", rsp_rdata, 32'h0000_7F01);

        one_req(1'b1, 2'b00, 1'b0, 32'h05, 32'hFFFF_FFAB);
        rsp_check("sb_05", 32'h0, 1'b0);
        one_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        rsp_check("lw_04", 32'h0000_AB01, 1'b0);
        one_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_BEEF);
        rsp_check("sh_0e", 32'h0, 1'b0);
        one_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        rsp_check("lw_0c", 32'hBEEF_0003, 1'b0);

        one_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
        rsp_check("lh_01_err", 32'h0, 1'b1);
        one_req(1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFE_F00D);
        rsp_check("sw_06_err", 32'h0, 1'b1);
        one_req(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_5555);
        rsp_check("sh_05_err", 32'h0, 1'b1);
        one_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        rsp_check("lw_04_unch", 32'h0000_AB01, 1'b0);
        one_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
        rsp_check("size11_err", 32'h0, 1'b1);
        one_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        rsp_check("lw_20_oor", 32'h0, 1'b1);
        one_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A_5A5A);
        rsp_check("sw_20_oor", 32'h0, 1'b1);
        one_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        rsp_check("lw_00_unch", 32'h0000_0000, 1'b0);
        one_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        rsp_check("lw_1c_last", 32'h0000_0007, 1'b0);

        set_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678);
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        rsp_check("b2b_sw", 32'h0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_check("b2b_lw", 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        check("b2b_after_valid", {31'b0, rsp_valid}, 32'd0);

        set_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_check("inflight_lw", 32'h0000_0007, 1'b0);
        reset = 1'b1;
        #1;
        zero_outputs("run_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_partial_idone", {31'b0, init_done}, 32'd0);
        reset = 1'b1;
        #1;
        zero_outputs("init_reset");
        @(negedge clk);
        reset = 1'b0;
        wait_init("init2");
        check("post_reinit_valid", {31'b0, rsp_valid}, 32'd0);
        one_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        rsp_check("lw_10_reinit", 32'h0000_0004, 1'b0);
        one_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        rsp_check("lw_08_reinit", 32'h0000_0002, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
